// File: rtl/extend_pipe.sv
// extend_pipe: registered immediate extender with prefix accumulation.
// Prefix beats shift IN_WIDTH-bit fields into an accumulator; a normal beat
// combines the accumulator with its own field and extends the result to
// OUT_WIDTH using one of four fill modes. A single output register stage is
// handshaked with valid/ready. in_ready is combinational.
module extend_pipe #(
   parameter int unsigned IN_WIDTH  = 4,
   parameter int unsigned OUT_WIDTH = 16
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [IN_WIDTH-1:0]  in_val,
   input  logic [1:0]           in_mode,
   input  logic                 in_prefix,
   input  logic                 in_flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [OUT_WIDTH-1:0] out_val,
   output logic                 out_prefixed
);

   // Prefix count saturates once the accumulator already spans the full output.
   localparam int unsigned PMAX = (OUT_WIDTH + IN_WIDTH - 1) / IN_WIDTH - 1;
   localparam int unsigned PC_W = (PMAX < 2) ? 1 : $clog2(PMAX + 1);

   localparam logic [1:0] MODE_ZERO = 2'b00;
   localparam logic [1:0] MODE_SIGN = 2'b01;
   localparam logic [1:0] MODE_ONES = 2'b10;
   localparam logic [1:0] MODE_HIGH = 2'b11;

   logic [OUT_WIDTH-1:0] acc;
   logic [PC_W-1:0]      pcount;

   logic                 accept;
   int unsigned          fwidth;
   logic [OUT_WIDTH-1:0] cat;
   logic [OUT_WIDTH-1:0] mask;
   logic [OUT_WIDTH-1:0] fld;
   logic                 sgn;
   logic [OUT_WIDTH-1:0] result;

   // Accept only when not flushing and the output register can take a result.
   assign in_ready = resetn && !in_flush && (!out_valid || out_ready);
   assign accept   = in_valid && in_ready;

   // Extension datapath: field width grows with the number of prefix beats.
   always_comb begin
      fwidth = (32'(pcount) + 32'd1) * IN_WIDTH;
      if (fwidth > OUT_WIDTH) begin
         fwidth = OUT_WIDTH;
      end
      cat    = (acc << IN_WIDTH) | OUT_WIDTH'(in_val);
      mask   = {OUT_WIDTH{1'b1}} >> (OUT_WIDTH - fwidth);
      fld    = cat & mask;
      // Top bit of the mask marks the sign position of the field.
      sgn    = |(fld & ~(mask >> 1));
      result = fld;
      case (in_mode)
         MODE_ZERO: result = fld;
         MODE_SIGN: result = sgn ? (fld | ~mask) : fld;
         MODE_ONES: result = fld | ~mask;
         MODE_HIGH: result = fld << (OUT_WIDTH - fwidth);
         default:   result = fld;
      endcase
   end

   // Prefix accumulator and saturating prefix count.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         acc    <= '0;
         pcount <= '0;
      end else if (in_flush) begin
         acc    <= '0;
         pcount <= '0;
      end else if (accept && in_prefix) begin
         acc <= (acc << IN_WIDTH) | OUT_WIDTH'(in_val);
         if (pcount != PC_W'(PMAX)) begin
            pcount <= pcount + PC_W'(1);
         end
      end else if (accept) begin
         acc    <= '0;
         pcount <= '0;
      end
   end

   // Output register: load on a normal beat, otherwise drain when taken.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         out_valid    <= 1'b0;
         out_val      <= '0;
         out_prefixed <= 1'b0;
      end else if (accept && !in_prefix) begin
         out_valid    <= 1'b1;
         out_val      <= result;
         out_prefixed <= (pcount != '0);
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_extend_pipe.sv
// Self-checking bench for extend_pipe (IN_WIDTH=4, OUT_WIDTH=16).
module tb_extend_pipe;

   localparam int unsigned IW   = 4;
   localparam int unsigned OW   = 16;
   localparam int          PMAX = 3;

   logic          clock;
   logic          resetn;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_val;
   logic [1:0]    in_mode;
   logic          in_prefix;
   logic          in_flush;
   logic          out_valid;
   logic          out_ready;
   logic [OW-1:0] out_val;
   logic          out_prefixed;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic          exp_valid;
   logic [OW-1:0] exp_val;
   logic          exp_pref;
   longint unsigned m_acc;
   int            m_pc;

   extend_pipe #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
      .clock        (clock),
      .resetn       (resetn),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_val       (in_val),
      .in_mode      (in_mode),
      .in_prefix    (in_prefix),
      .in_flush     (in_flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_val      (out_val),
      .out_prefixed (out_prefixed)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Extension computed arithmetically from the fill-mode rules.
   function automatic longint unsigned ref_ext(input longint unsigned acc, input int pc,
                                               input longint unsigned v, input int mode);
      longint unsigned full, f, p_w, p_out;
      int w;
      w = (pc + 1) * IW;
      if (w > OW) w = OW;
      full  = acc * (64'd1 << IW) + v;
      p_w   = 64'd1 << w;
      p_out = 64'd1 << OW;
      f     = full % p_w;
      case (mode)
         0: ref_ext = f;
         1: ref_ext = (f >= p_w / 2) ? (f + p_out - p_w) : f;
         2: ref_ext = f + p_out - p_w;
         default: ref_ext = f * (64'd1 << (OW - w));
      endcase
   endfunction

   // One clock: apply inputs, check in_ready, advance model, check outputs.
   task automatic step(input bit v, input logic [3:0] val, input logic [1:0] mode,
                       input bit pre, input bit fl, input bit ordy, input bit rstn);
      bit exp_rdy;
      bit acc_now;
      in_valid  = v;
      in_val    = val;
      in_mode   = mode;
      in_prefix = pre;
      in_flush  = fl;
      out_ready = ordy;
      resetn    = rstn;
      #1;
      exp_rdy = rstn && !fl && (!exp_valid || ordy);
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (!rstn) begin
         exp_valid = 1'b0;
         exp_val   = '0;
         exp_pref  = 1'b0;
         m_acc     = 0;
         m_pc      = 0;
      end else begin
         acc_now = v && exp_rdy;
         if (acc_now && !pre) begin
            exp_val   = OW'(ref_ext(m_acc, m_pc, 64'(val), int'(mode)));
            exp_pref  = (m_pc != 0);
            exp_valid = 1'b1;
         end else if (ordy) begin
            exp_valid = 1'b0;
         end
         if (fl || (acc_now && !pre)) begin
            m_acc = 0;
            m_pc  = 0;
         end else if (acc_now && pre) begin
            m_acc = (m_acc * 16 + 64'(val)) % 65536;
            m_pc  = (m_pc + 1 > PMAX) ? PMAX : m_pc + 1;
         end
      end
      @(posedge clock);
      @(negedge clock);
      check("out_valid", 32'(out_valid), 32'(exp_valid));
      check("out_val", 32'(out_val), 32'(exp_val));
      check("out_prefixed", 32'(out_prefixed), 32'(exp_pref));
   endtask

   initial begin
      exp_valid = 1'b0;
      exp_val   = '0;
      exp_pref  = 1'b0;
      m_acc     = 0;
      m_pc      = 0;
      in_valid = 0; in_val = '0; in_mode = '0; in_prefix = 0; in_flush = 0;
      out_ready = 0; resetn = 0;
      @(negedge clock);

      // Reset state
      step(1, 4'h5, 2'b00, 0, 0, 1, 0);
      step(0, 4'h0, 2'b00, 0, 0, 1, 0);
      check("reset_val", 32'(out_val), 32'h0);

      // 1: back-to-back modes
      step(1, 4'hA, 2'b01, 0, 0, 1, 1);
      check("tp1_sign", 32'(out_val), 32'hFFFA);
      step(1, 4'hA, 2'b00, 0, 0, 1, 1);
      check("tp1_zero", 32'(out_val), 32'h000A);
      step(1, 4'h2, 2'b10, 0, 0, 1, 1);
      check("tp1_ones", 32'(out_val), 32'hFFF2);
      step(1, 4'hA, 2'b11, 0, 0, 1, 1);
      check("tp1_high", 32'(out_val), 32'hA000);
      check("tp1_pref", 32'(out_prefixed), 32'h0);

      // 2: prefix sequences
      step(1, 4'h1, 2'b00, 1, 0, 1, 1);
      step(1, 4'h8, 2'b01, 0, 0, 1, 1);
      check("tp2_a", 32'(out_val), 32'h0018);
      check("tp2_a_pref", 32'(out_prefixed), 32'h1);
      step(1, 4'h9, 2'b00, 1, 0, 1, 1);
      step(1, 4'h8, 2'b01, 0, 0, 1, 1);
      check("tp2_b", 32'(out_val), 32'hFF98);
      step(1, 4'h9, 2'b00, 1, 0, 1, 1);
      step(1, 4'h8, 2'b11, 0, 0, 1, 1);
      check("tp2_c", 32'(out_val), 32'h9800);

      // 3: prefix saturation
      step(1, 4'h1, 2'b00, 1, 0, 1, 1);
      step(1, 4'h2, 2'b00, 1, 0, 1, 1);
      step(1, 4'h3, 2'b00, 1, 0, 1, 1);
      step(1, 4'h4, 2'b00, 1, 0, 1, 1);
      step(1, 4'h5, 2'b00, 0, 0, 1, 1);
      check("tp3", 32'(out_val), 32'h2345);
      check("tp3_pref", 32'(out_prefixed), 32'h1);

      // 4: output hold, then drain with simultaneous input
      step(1, 4'h6, 2'b00, 0, 0, 0, 1);
      step(1, 4'h7, 2'b00, 0, 0, 0, 1);
      step(1, 4'h7, 2'b00, 1, 0, 0, 1);
      check("tp4_hold", 32'(out_val), 32'h2345);
      step(1, 4'h3, 2'b00, 0, 0, 1, 1);
      check("tp4", 32'(out_val), 32'h0003);
      check("tp4_valid", 32'(out_valid), 32'h1);

      // 5: flush discards prefix
      step(1, 4'hF, 2'b00, 1, 0, 1, 1);
      step(1, 4'h9, 2'b01, 0, 1, 1, 1);
      step(1, 4'h3, 2'b01, 0, 0, 1, 1);
      check("tp5", 32'(out_val), 32'h0003);
      check("tp5_pref", 32'(out_prefixed), 32'h0);

      // 6: reset mid-operation clears pending output and prefix
      step(1, 4'h1, 2'b00, 1, 0, 1, 1);
      step(1, 4'h2, 2'b00, 1, 0, 1, 1);
      step(1, 4'h3, 2'b00, 1, 0, 1, 1);
      step(1, 4'h4, 2'b00, 0, 0, 1, 1);
      check("tp6_pending", 32'(out_val), 32'h1234);
      step(0, 4'h0, 2'b00, 0, 0, 0, 1);
      step(0, 4'h0, 2'b00, 0, 0, 0, 0);
      check("tp6_rst_val", 32'(out_val), 32'h0);
      step(1, 4'h7, 2'b00, 1, 0, 1, 1);
      step(0, 4'h0, 2'b00, 0, 0, 1, 0);
      step(1, 4'h1, 2'b01, 0, 0, 1, 1);
      check("tp6", 32'(out_val), 32'h0001);
      check("tp6_pref", 32'(out_prefixed), 32'h0);

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 4) != 0, 4'($urandom), 2'($urandom), ($urandom % 3) == 0,
              ($urandom % 16) == 0, ($urandom % 4) != 0, ($urandom % 64) != 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
